// File: rtl/cim_multi_accumulator.sv
// Multi-lane shift-weighted partial-sum accumulator for the CIM output path.
// Bit-serial terms are added or subtracted per lane, with optional clamping and a held-result handshake.
module cim_multi_accumulator #(
  parameter int NCH    = 4,
  parameter int IN_W   = 27,
  parameter int ACC_W  = 51,
  parameter int SH_W   = 6,
  parameter int CNT_W  = 8,
  parameter int SAT_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCH*IN_W-1:0]    in_data,
  input  logic [SH_W-1:0]        in_shift,
  input  logic                   in_neg,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH*ACC_W-1:0]   out_data,
  output logic [NCH-1:0]         out_ovf,
  output logic [CNT_W-1:0]       out_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                 state, state_nxt;
  logic [NCH*ACC_W-1:0]   acc, acc_nxt;
  logic [NCH-1:0]         ovf, ovf_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;

  logic [NCH*ACC_W-1:0]   term_all;
  logic [NCH*ACC_W-1:0]   sum_all;
  logic [NCH-1:0]         add_ovf;
  logic                   shift_big;
  logic                   beat;
  logic                   start_new;
  logic                   add_on;

  // Any shift that moves every bit past the accumulator top yields a zero term.
  assign shift_big = (int'(in_shift) >= ACC_W);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    logic signed [IN_W-1:0]  lane_in;
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_cur;
    logic signed [ACC_W-1:0] sum;
    logic                    lane_ovf;

    assign lane_in  = in_data[i*IN_W +: IN_W];
    assign ext      = ACC_W'(lane_in);
    assign shifted  = shift_big ? '0 : (ext << in_shift);
    assign term     = in_neg ? -shifted : shifted;
    assign acc_cur  = acc[i*ACC_W +: ACC_W];
    assign sum      = acc_cur + term;
    // Signed overflow: operands agree in sign but the sum does not.
    assign lane_ovf = (acc_cur[ACC_W-1] == term[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_cur[ACC_W-1]);

    assign add_ovf[i]                  = lane_ovf;
    assign term_all[i*ACC_W +: ACC_W]  = term;
    assign sum_all[i*ACC_W +: ACC_W]   = (SAT_EN != 0 && lane_ovf)
                                         ? (acc_cur[ACC_W-1] ? ACC_MIN : ACC_MAX)
                                         : sum;
  end

  assign in_ready = (state != S_HOLD) | out_ready;
  assign beat     = in_valid & in_ready & ~clr;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    start_new = 1'b0;
    add_on    = 1'b0;

    case (state)
      S_IDLE: start_new = beat;
      S_ACC: begin
        start_new = beat & in_first;
        add_on    = beat & ~in_first;
      end
      S_HOLD: begin
        if (out_ready) begin
          start_new = beat;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (start_new) begin
      acc_nxt = term_all;
      ovf_nxt = '0;
      cnt_nxt = CNT_W'(1);
    end else if (add_on) begin
      acc_nxt = sum_all;
      ovf_nxt = ovf | add_ovf;
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end

    if (start_new || add_on) begin
      state_nxt = in_last ? S_HOLD : S_ACC;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      // NOTE: the accumulator bank is cleared on reset because out_data exposes it directly.
      state <= S_IDLE;
      acc   <= '0;
      ovf   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign out_valid = (state == S_HOLD);
  assign out_data  = acc;
  assign out_ovf   = ovf;
  assign out_cnt   = cnt;

endmodule
